// File: rtl/mlp_stream_fifo.sv
// mlp_stream_fifo: synchronous first-word-fall-through stream FIFO with a
// valid/ready handshake on both sides, a synchronous flush and an occupancy
// count.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous active-high reset (clears pointers and count)
//   flush_i      synchronous discard of all stored entries
//   in_valid_i   producer offers in_data_i
//   in_data_i    write word
//   in_ready_o   FIFO can accept a word this cycle (not full)
//   out_valid_o  out_data_o holds the oldest stored word (not empty)
//   out_data_o   oldest stored word
//   out_ready_i  consumer takes the word
//   count_o      number of stored entries
//   full_o       count_o == Depth
//   empty_o      count_o == 0
module mlp_stream_fifo #(
  parameter int unsigned DWidth = 32,
  parameter int unsigned Depth  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [DWidth-1:0]          in_data_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [DWidth-1:0]          out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [DWidth-1:0] storage [Depth];
  logic [AddrW-1:0]  rd_ptr;
  logic [AddrW-1:0]  wr_ptr;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              push;
  logic              pop;

  // Handshakes depend only on registered flags, never on the other side's
  // same-cycle request, so a full FIFO rejects a push even while popping.
  assign push = in_valid_i & ~full_q;
  assign pop  = out_ready_i & ~empty_q;

  // Occupancy after this edge when neither reset nor flush is active.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CntW'(1);
      2'b01:   count_nxt = count - CntW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, count and the registered full/empty flags.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AddrW'(1);
      if (pop)  rd_ptr <= rd_ptr + AddrW'(1);
      count   <= count_nxt;
      full_q  <= (count_nxt == CntW'(Depth));
      empty_q <= (count_nxt == '0);
    end
  end

  // Storage array has no reset; only accepted pushes write it.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i && !flush_i) begin
      storage[wr_ptr] <= in_data_i;
    end
  end

  assign in_ready_o  = ~full_q;
  assign out_valid_o = ~empty_q;
  assign out_data_o  = storage[rd_ptr];
  assign count_o     = count;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule

// File: doc/mlp_stream_fifo.md
MLP_STREAM_FIFO -- requirements
Module: mlp_stream_fifo

Interface
REQ-001 SHALL have parameter DWidth, default 32, data word width in bits.
REQ-002 SHALL have parameter Depth, default 4, entry count; power of two, >= 2.
REQ-003 SHALL have clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have flush_i  input  1  synchronous discard of all stored entries.
REQ-006 SHALL have in_valid_i  input  1  producer offers in_data_i.
REQ-007 SHALL have in_data_i  input  DWidth  write word.
REQ-008 SHALL have in_ready_o  output  1  FIFO can accept a word this cycle.
REQ-009 SHALL have out_valid_o  output  1  out_data_o holds the oldest stored word.
REQ-010 SHALL have out_data_o  output  DWidth  oldest stored word (first-word-fall-through).
REQ-011 SHALL have out_ready_i  input  1  consumer (downstream register stage write enable) takes the word.
REQ-012 SHALL have count_o  output  $clog2(Depth)+1  number of stored entries.
REQ-013 SHALL have full_o / empty_o  output  1 each  count_o==Depth / count_o==0.

Function
REQ-014 SHALL define push = in_valid_i & in_ready_o and pop = out_valid_o & out_ready_i; only these move data.
REQ-015 SHALL drive in_ready_o = !full_o, a function of state only, independent of out_ready_i in the same cycle.
REQ-016 SHALL drive out_valid_o = !empty_o, independent of in_valid_i in the same cycle.
REQ-017 SHALL present out_data_o = storage[rd_ptr] whenever out_valid_o=1; value undefined (don't-care) when 0.
REQ-018 SHALL store a pushed word at wr_ptr on the edge; word visible at out_data_o no earlier than the next cycle (min latency in->out = 1 cycle).
REQ-019 SHALL keep rd_ptr/wr_ptr as log2(Depth)-bit counters wrapping Depth-1 -> 0, plus count register.
REQ-020 SHALL update count: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
REQ-021 SHALL accept simultaneous push and pop whenever 0 < count < Depth, preserving order.
REQ-022 SHALL not push when full even if pop occurs the same cycle (in_ready_o=0 governs); pop still proceeds.
REQ-023 SHALL not pop when empty even if push occurs the same cycle; pushed word appears next cycle.
REQ-024 SHALL preserve strict FIFO order across any number of pointer wrap-arounds.
REQ-025 SHALL ignore in_data_i when push=0 and hold storage contents unchanged.
REQ-026 SHALL, on flush_i=1 (rst_i=0), set rd_ptr=wr_ptr=0, count=0 on the edge, discarding any same-cycle push and pop.
REQ-027 SHALL not require storage array reset; only pointers and count are reset.

Reset
REQ-028 SHALL, on rst_i=1 at an edge, set rd_ptr=0, wr_ptr=0, count=0 regardless of all other inputs, including mid-stream.
REQ-029 SHALL give post-reset outputs: count_o=0, empty_o=1, full_o=0, out_valid_o=0, in_ready_o=1.
REQ-030 SHALL give rst_i priority over flush_i, push and pop.

Verification (DWidth=32, Depth=4)
REQ-031 SHALL verify fill: push 0xA0..0xA3 with out_ready_i=0 -> count_o 1,2,3,4; after 4th, full_o=1, in_ready_o=0; 5th offer 0xA4 not stored.
REQ-032 SHALL verify drain: from full, out_ready_i=1, in_valid_i=0 -> out_data_o 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, then empty_o=1, out_valid_o=0.
REQ-033 SHALL verify empty bypass timing: empty, push 0x55 with out_ready_i=1 -> out_valid_o=0 that cycle; next cycle out_valid_o=1, out_data_o=0x55, then popped, count_o=0.
REQ-034 SHALL verify full simultaneous: full with 0xB0..0xB3, in_valid_i=1 (0xC0), out_ready_i=1 -> 0xB0 popped, 0xC0 rejected, count_o=3; next cycle 0xC0 accepted, count_o stays 3.
REQ-035 SHALL verify wrap/streaming: 20 words 0..19 pushed with in_valid_i=out_ready_i=1 continuously after 1 prefill -> output sequence 0..19 in order, count_o steady at 1.
REQ-036 SHALL verify reset/flush mid-op: count_o=3, assert flush_i with push+pop -> count_o=0, empty_o=1 next cycle; repeat with rst_i and flush_i both 1 -> identical reset state.
